// File: rtl/flash_read_arbiter_if.sv
// Bundle of requester, response and flash-reader signals around flash_read_arbiter.
// slave = arbiter side; master = requesters, consumers and flash reader.
interface flash_read_arbiter_if #(
  parameter int ADDR_W = 24,
  parameter int LEN_W  = 8
);
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [LEN_W-1:0]  req0_len;
  logic              req0_ack;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [LEN_W-1:0]  req1_len;
  logic              req1_ack;

  logic              rsp0_valid;
  logic [7:0]        rsp0_data;
  logic              rsp0_last;
  logic              rsp0_ready;
  logic              rsp1_valid;
  logic [7:0]        rsp1_data;
  logic              rsp1_last;
  logic              rsp1_ready;

  logic              fl_read;
  logic [ADDR_W-1:0] fl_addr;
  logic              fl_ready;
  logic [7:0]        fl_data;

  logic              busy;
  logic              grant;
  logic              err;

  modport slave (
    input  req0_valid, req0_addr, req0_len, req1_valid, req1_addr, req1_len,
    output req0_ack, req1_ack,
    output rsp0_valid, rsp0_data, rsp0_last, rsp1_valid, rsp1_data, rsp1_last,
    input  rsp0_ready, rsp1_ready,
    output fl_read, fl_addr,
    input  fl_ready, fl_data,
    output busy, grant, err
  );

  modport master (
    output req0_valid, req0_addr, req0_len, req1_valid, req1_addr, req1_len,
    input  req0_ack, req1_ack,
    input  rsp0_valid, rsp0_data, rsp0_last, rsp1_valid, rsp1_data, rsp1_last,
    output rsp0_ready, rsp1_ready,
    input  fl_read, fl_addr,
    output fl_ready, fl_data,
    input  busy, grant, err
  );
endinterface

// File: rtl/flash_read_arbiter.sv
// Two-requester round-robin burst arbiter in front of a byte-wide flash read engine.
// Optional WAIT timeout with 0xFF abort byte is enabled by defining FLASH_ARB_TIMEOUT_EN.
module flash_read_arbiter #(
  parameter int ADDR_W      = 24,
  parameter int LEN_W       = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input logic                 clk,
  input logic                 rstn,
  flash_read_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, DELIVER} state_e;

  state_e            state_q, state_d;
  logic              grant_q, grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [7:0]        data_q, data_d;
  logic [1:0]        ack_q, ack_d;
  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic              last_q, last_d;
  logic              fl_read_q, fl_read_d;
  logic              busy_q, busy_d;
  logic              sel;
  logic              rsp_ready;
  logic              tmo_hit;

  assign rsp_ready = grant_q ? bus.rsp1_ready : bus.rsp0_ready;

`ifdef FLASH_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q;

  // Counts WAIT cycles without fl_ready; fires on the TIMEOUT_CYC-th such cycle.
  assign tmo_hit = (state_q == WAIT) && !bus.fl_ready && (tmo_q == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    tmo_d = '0;
    if (state_q == WAIT && !bus.fl_ready) tmo_d = tmo_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= tmo_hit;
    end
  end

  assign bus.err = err_q;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TIMEOUT_CYC;
  assign tmo_hit        = 1'b0;
  assign bus.err        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.req0_valid || bus.req1_valid) state_d = WAIT;
      WAIT:    if (bus.fl_ready || tmo_hit) state_d = DELIVER;
      DELIVER: if (rsp_ready) state_d = last_q ? IDLE : WAIT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    // Requester 1 wins only when alone or when requester 0 owned the previous burst.
    sel         = bus.req1_valid && (!bus.req0_valid || !grant_q);
    grant_d     = grant_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    data_d      = data_q;
    last_d      = last_q;
    rsp_valid_d = rsp_valid_q;
    ack_d       = '0;
    fl_read_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req0_valid || bus.req1_valid) begin
          grant_d   = sel;
          ack_d     = sel ? 2'b10 : 2'b01;
          fl_read_d = 1'b1;
          addr_d    = sel ? bus.req1_addr : bus.req0_addr;
          rem_d     = sel ? bus.req1_len  : bus.req0_len;
        end
      end
      WAIT: begin
        if (bus.fl_ready) begin
          data_d      = bus.fl_data;
          last_d      = (rem_q == '0);
          rsp_valid_d = grant_q ? 2'b10 : 2'b01;
        end else if (tmo_hit) begin
          data_d      = 8'hFF;
          last_d      = 1'b1;
          rsp_valid_d = grant_q ? 2'b10 : 2'b01;
        end
      end
      DELIVER: begin
        if (rsp_ready) begin
          rsp_valid_d = '0;
          if (!last_q) begin
            addr_d    = addr_q + 1'b1;
            rem_d     = rem_q - 1'b1;
            fl_read_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      grant_q     <= 1'b1;
      addr_q      <= '0;
      rem_q       <= '0;
      data_q      <= '0;
      last_q      <= 1'b0;
      rsp_valid_q <= '0;
      ack_q       <= '0;
      fl_read_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      grant_q     <= grant_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      data_q      <= data_d;
      last_q      <= last_d;
      rsp_valid_q <= rsp_valid_d;
      ack_q       <= ack_d;
      fl_read_q   <= fl_read_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.req0_ack   = ack_q[0];
  assign bus.req1_ack   = ack_q[1];
  assign bus.rsp0_valid = rsp_valid_q[0];
  assign bus.rsp1_valid = rsp_valid_q[1];
  assign bus.rsp0_data  = data_q;
  assign bus.rsp1_data  = data_q;
  assign bus.rsp0_last  = last_q;
  assign bus.rsp1_last  = last_q;
  assign bus.fl_read    = fl_read_q;
  assign bus.fl_addr    = addr_q;
  assign bus.busy       = busy_q;
  assign bus.grant      = grant_q;

endmodule
